vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_timing.sv | 197 +++++++++++++++++++
 tb/tb_vga_timing.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// vga_timing -- VGA raster timing generator gated by PLL lock.
//
// Purpose:
//   Waits for the pixel-clock PLL to report lock and then for SETTLE_CYCLES
//   further clocks of uninterrupted lock. After that it scans an
//   H_total x V_total raster and produces syncs, a visible-area flag,
//   line/frame start pulses and an optional test pattern.
//   Losing lock or asserting reset returns every output to its idle value.
//
// Ports:
//   clock_in     in   1   pixel clock; every flop runs on its rising edge
//   reset        in   1   synchronous active-high reset
//   locked       in   1   PLL lock, already synchronous to clock_in
//   hsync        out  1   horizontal sync, active low
//   vsync        out  1   vertical sync, active low
//   active       out  1   high while (x,y) is inside the visible area
//   x            out  10  horizontal position, 0..H_total-1
//   y            out  10  vertical position, 0..V_total-1
//   line_start   out  1   high on the cycle where x==0
//   frame_start  out  1   high on the cycle where x==0 and y==0
//   rgb          out  3   pixel colour {r,g,b}
//
// Configuration macro:
//   VGA_TIMING_RAINBOW_EN -- when defined, rgb shows eight vertical colour
//   bars across the visible width. When undefined, rgb is held at 0.
//
// Every output is a flop that loads from the next-cycle counter values.
// The syncs, pulses and colour therefore always describe the (x,y) shown
// in the same cycle.

module vga_timing #(
    parameter int H_VISIBLE     = 640,
    parameter int H_FRONT       = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BACK        = 48,
    parameter int V_VISIBLE     = 480,
    parameter int V_FRONT       = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BACK        = 33,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       locked,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start,
    output logic [2:0] rgb
);

    localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  settle_q, settle_d;
    logic [9:0]  x_q, y_q, x_d, y_d;
    logic        hsync_q, vsync_q, active_q, line_q, frame_q;
    logic        hsync_d, vsync_d, active_d, line_d, frame_d;
    logic [2:0]  rgb_q, rgb_d;
    logic        run_d;

`ifdef VGA_TIMING_RAINBOW_EN
    localparam logic [9:0] BAR_W = 10'(H_VISIBLE / 8);

    // Colour bar index: the visible width is split into eight equal bars.
    function automatic logic [2:0] bar_index(input logic [9:0] xv);
        return 3'(xv / BAR_W);
    endfunction
`endif

    // Next state, settle counter and raster position.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        x_d      = 10'd0;
        y_d      = 10'd0;
        case (state_q)
            WAIT_LOCK: begin
                settle_d = 8'd0;
                if (locked) begin
                    state_d = SETTLE;
                end else begin
                    state_d = WAIT_LOCK;
                end
            end
            SETTLE: begin
                if (!locked) begin
                    state_d  = WAIT_LOCK;
                    settle_d = 8'd0;
                end else if (settle_q >= SETTLE_LAST) begin
                    // Counters stay at 0, so the first RUN cycle is (0,0).
                    state_d  = RUN;
                    settle_d = 8'd0;
                end else begin
                    state_d  = SETTLE;
                    settle_d = settle_q + 8'd1;
                end
            end
            RUN: begin
                if (!locked) begin
                    state_d = WAIT_LOCK;
                end else begin
                    state_d = RUN;
                    // ">=" lets a corrupted counter recover on the next wrap.
                    if (x_q >= H_LAST) begin
                        x_d = 10'd0;
                        if (y_q >= V_LAST) begin
                            y_d = 10'd0;
                        end else begin
                            y_d = y_q + 10'd1;
                        end
                    end else begin
                        x_d = x_q + 10'd1;
                        y_d = y_q;
                    end
                end
            end
            default: begin
                state_d  = WAIT_LOCK;
                settle_d = 8'd0;
            end
        endcase
    end

    // Output values for the position that will be presented next cycle.
    always_comb begin
        run_d    = (state_d == RUN);
        hsync_d  = !(run_d && (x_d >= HS_START) && (x_d < HS_END));
        vsync_d  = !(run_d && (y_d >= VS_START) && (y_d < VS_END));
        active_d = run_d && (x_d < H_VIS) && (y_d < V_VIS);
        line_d   = run_d && (x_d == 10'd0);
        frame_d  = run_d && (x_d == 10'd0) && (y_d == 10'd0);
`ifdef VGA_TIMING_RAINBOW_EN
        if (active_d) begin
            rgb_d = bar_index(x_d);
        end else begin
            rgb_d = 3'b000;
        end
`else
        rgb_d = 3'b000;
`endif
    end

    // State, counters and registered outputs; reset overrides everything.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q  <= WAIT_LOCK;
            settle_q <= 8'd0;
            x_q      <= 10'd0;
            y_q      <= 10'd0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            active_q <= 1'b0;
            line_q   <= 1'b0;
            frame_q  <= 1'b0;
            rgb_q    <= 3'b000;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            x_q      <= x_d;
            y_q      <= y_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            active_q <= active_d;
            line_q   <= line_d;
            frame_q  <= frame_d;
            rgb_q    <= rgb_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign active      = active_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_q;
    assign frame_start = frame_q;
    assign rgb         = rgb_q;

endmodule

// File: tb/tb_vga_timing.sv
// Testbench for vga_timing. It uses a reduced raster so that whole frames
// fit in a short run. Every cycle it compares all outputs against a
// reference built from a lock/settle mode and a "cycles since RUN began"
// count. The expected position comes from that count with plain
// modulo/divide arithmetic.

module tb_vga_timing;

    localparam int HV = 40, HF = 4, HS = 8, HB = 6;
    localparam int VV = 12, VF = 2, VS = 2, VB = 3;
    localparam int ST = 16;
    localparam int HT = HV + HF + HS + HB;   // 58
    localparam int VT = VV + VF + VS + VB;   // 19
    localparam int FRAME = HT * VT;          // 1102

    logic       clk;
    logic       reset;
    logic       locked;
    logic       hsync, vsync, active, line_start, frame_start;
    logic [9:0] x, y;
    logic [2:0] rgb;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model state: 0 = waiting for lock, 1 = settling, 2 = running
    int m_mode = 0;
    int m_seen = 0;   // locked cycles counted while settling
    int m_t    = 0;   // cycles since the first RUN cycle

    vga_timing #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SETTLE_CYCLES(ST)
    ) dut (
        .clock_in(clk), .reset(reset), .locked(locked),
        .hsync(hsync), .vsync(vsync), .active(active),
        .x(x), .y(y), .line_start(line_start), .frame_start(frame_start),
        .rgb(rgb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_update(input logic rst, input logic lk);
        if (rst) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (lk) begin
                m_mode = 1;
                m_seen = 0;
            end
        end else if (m_mode == 1) begin
            if (!lk) begin
                m_mode = 0;
            end else begin
                m_seen++;
                if (m_seen == ST) begin
                    m_mode = 2;
                    m_t    = 0;
                end
            end
        end else begin
            if (!lk) m_mode = 0;
            else     m_t++;
        end
    endtask

    task automatic check_all();
        int  ex, ey, e_rgb;
        bit  run, e_hs, e_vs, e_act;
        run   = (m_mode == 2);
        ex    = run ? (m_t % HT) : 0;
        ey    = run ? ((m_t / HT) % VT) : 0;
        e_hs  = !(run && ex >= HV + HF && ex < HV + HF + HS);
        e_vs  = !(run && ey >= VV + VF && ey < VV + VF + VS);
        e_act = run && ex < HV && ey < VV;
`ifdef VGA_TIMING_RAINBOW_EN
        e_rgb = e_act ? ex / (HV / 8) : 0;
`else
        e_rgb = 0;
`endif
        chk("x", int'(x), ex);
        chk("y", int'(y), ey);
        chk("hsync", int'(hsync), int'(e_hs));
        chk("vsync", int'(vsync), int'(e_vs));
        chk("active", int'(active), int'(e_act));
        chk("line_start", int'(line_start), int'(run && ex == 0));
        chk("frame_start", int'(frame_start), int'(run && ex == 0 && ey == 0));
        chk("rgb", int'(rgb), e_rgb);
    endtask

    task automatic step(input logic rst, input logic lk);
        reset  = rst;
        locked = lk;
        @(posedge clk);
        model_update(rst, lk);
        @(negedge clk);
        cyc++;
        check_all();
    endtask

    initial begin
        int n, last_fs, fs_gap, cnt_line, cnt_vs, cnt_act, cnt_hs;
        bit hs_prev, hit;
        reset  = 1'b1;
        locked = 1'b0;

        // Reset with random lock level; outputs must be idle.
        for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom_range(0, 1)));
        step(1'b1, 1'b1);

        // Release reset with lock already high: first frame after 1+ST cycles.
        n = 0;
        do begin
            step(1'b0, 1'b1);
            n++;
        end while (!frame_start && n < 100);
        chk("settle_latency", n, ST + 1);

        // One full frame starting on the frame_start cycle.
        last_fs = 0; fs_gap = -1;
        cnt_line = int'(line_start); cnt_vs = int'(!vsync);
        cnt_act = int'(active); cnt_hs = int'(!hsync);
        hs_prev = hsync;
        for (int k = 1; k <= FRAME; k++) begin
            step(1'b0, 1'b1);
            if (frame_start) begin
                fs_gap  = k - last_fs;
                last_fs = k;
            end
            if (k < FRAME) begin
                cnt_line += int'(line_start);
                cnt_vs   += int'(!vsync);
                cnt_act  += int'(active);
                cnt_hs   += int'(!hsync);
                if (hs_prev && !hsync) chk("hsync_fall_x", int'(x), HV + HF);
                hs_prev = hsync;
            end
        end
        chk("frame_period", fs_gap, FRAME);
        chk("line_starts_per_frame", cnt_line, VT);
        chk("vsync_low_cycles", cnt_vs, VS * HT);
        chk("active_cycles", cnt_act, HV * VV);
        chk("hsync_low_cycles", cnt_hs, HS * VT);

        // Drop lock mid-frame, then relock.
        n = 0;
        while (!(x == 10'd30 && y == 10'd5) && n < FRAME + 10) begin
            step(1'b0, 1'b1);
            n++;
        end
        hit = (x == 10'd30 && y == 10'd5);
        chk("reach_drop_point", int'(hit), 1);
        step(1'b0, 1'b0);
        chk("drop_idle_x", int'(x), 0);
        n = 0;
        do begin
            step(1'b0, 1'b1);
            n++;
        end while (!frame_start && n < 100);
        chk("relock_latency", n, ST + 1);

        // Reset exactly at the last raster position: no wrap pulse.
        n = 0;
        while (!(x == 10'(HT - 1) && y == 10'(VT - 1)) && n < FRAME + 10) begin
            step(1'b0, 1'b1);
            n++;
        end
        hit = (x == 10'(HT - 1) && y == 10'(VT - 1));
        chk("reach_corner", int'(hit), 1);
        step(1'b1, 1'b1);
        chk("corner_no_frame_pulse", int'(frame_start), 0);
        chk("corner_no_line_pulse", int'(line_start), 0);
        // Held in WAIT_LOCK: one locked cycle is needed before settling.
        n = 0;
        do begin
            step(1'b0, 1'b1);
            n++;
        end while (!frame_start && n < 100);
        chk("post_reset_latency", n, ST + 1);

        // Randomized lock glitches and resets against the model.
        for (int i = 0; i < 4000; i++) begin
            step(1'($urandom_range(0, 999) < 3), 1'($urandom_range(0, 99) < 97));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
